// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   data port. One command per cycle, combinational grants, round-robin on
//   conflict, fully pipelined reads returned in grant order after MEM_LAT.
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request, byte address
//   if_gnt/if_rvalid/if_rdata       fetch grant, read-valid pulse, read data
//   d_req/d_we/d_addr/d_wdata       data request, write enable, address, data
//   d_gnt/d_rvalid/d_rdata          data grant, read-valid pulse, read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata             single-port memory command and read data
//   stall                           a request is present but not granted
//   err_misalign                    pulse per granted misaligned request
//   conflict_cnt                    saturating count of both-request cycles
module unified_mem_arbiter #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          err_misalign,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    port_e               last_winner;
    logic                conflict;
    logic                granted;
    logic                misalign;
    logic                rd_issue;
    logic [31:0]         sel_addr;
    logic                unused_addr_bits;

    // Read-tracking pipeline: valid, owner (1 = data port), misaligned.
    logic [MEM_LAT-1:0]  pipe_vld;
    logic [MEM_LAT-1:0]  pipe_own;
    logic [MEM_LAT-1:0]  pipe_mis;
    logic                resp_vld;
    logic [DW-1:0]       resp_data;
    logic [DW-1:0]       if_rdata_q;
    logic [DW-1:0]       d_rdata_q;

    always_comb begin
        // Grants are suppressed while reset is held low.
        conflict = reset & if_req & d_req;
        d_gnt    = reset & d_req & (~if_req | (last_winner == PORT_IF));
        if_gnt   = reset & if_req & ~d_gnt;
        granted  = if_gnt | d_gnt;
        sel_addr = d_gnt ? d_addr : if_addr;
        misalign = granted & (sel_addr[1:0] != 2'b00);

        err_misalign = misalign;
        mem_en       = granted & ~misalign;
        mem_we       = mem_en & d_gnt & d_we;
        mem_addr     = sel_addr[AW+1:2];
        mem_wdata    = d_gnt ? d_wdata : '0;

        // Fetches are always reads; misaligned reads still get a response.
        rd_issue = if_gnt | (d_gnt & ~d_we);
        stall    = (if_req & ~if_gnt) | (d_req & ~d_gnt);
    end

    assign unused_addr_bits = ^sel_addr[31:AW+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            pipe_own <= '0;
            pipe_mis <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_own[0] <= d_gnt;
            pipe_mis[0] <= misalign;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
                pipe_mis[i] <= pipe_mis[i-1];
            end
        end
    end

    always_comb begin
        resp_vld  = pipe_vld[MEM_LAT-1];
        resp_data = pipe_mis[MEM_LAT-1] ? '0 : mem_rdata;
        if_rvalid = resp_vld & ~pipe_own[MEM_LAT-1];
        d_rvalid  = resp_vld &  pipe_own[MEM_LAT-1];
        // Response data is passed straight through in the valid cycle and
        // held from a register otherwise.
        if_rdata  = if_rvalid ? resp_data : if_rdata_q;
        d_rdata   = d_rvalid  ? resp_data : d_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            last_winner  <= PORT_IF;
            conflict_cnt <= '0;
        end else begin
            if (if_rvalid) if_rdata_q <= resp_data;
            if (d_rvalid)  d_rdata_q  <= resp_data;
            if (conflict) begin
                last_winner <= d_gnt ? PORT_D : PORT_IF;
                if (conflict_cnt != 16'hFFFF)
                    conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- DUT A (MEM_LAT = 1) ----
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [31:0]   d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall, err_misalign;
    logic [15:0]   conflict_cnt;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .err_misalign(err_misalign), .conflict_cnt(conflict_cnt)
    );

    // ---- DUT B (MEM_LAT = 2), used for latency and mid-flight reset ----
    logic          reset_b;
    logic          if_req_b, if_gnt_b, if_rvalid_b;
    logic [31:0]   if_addr_b;
    logic [DW-1:0] if_rdata_b;
    logic          d_gnt_b, d_rvalid_b;
    logic [DW-1:0] d_rdata_b;
    logic          mem_en_b, mem_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;
    logic          stall_b, err_misalign_b;
    logic [15:0]   conflict_cnt_b;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut_b (
        .clk(clk), .reset(reset_b),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .stall(stall_b), .err_misalign(err_misalign_b), .conflict_cnt(conflict_cnt_b)
    );

    // ---- memory models ----
    logic [31:0] mem_a   [0:4095];
    logic [31:0] mem_b   [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] rd_a, rd_b0, rd_b1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_a[mem_addr] <= mem_wdata;
            else        rd_a <= mem_a[mem_addr];
        end
    end
    assign mem_rdata = rd_a;

    always @(posedge clk) begin
        if (mem_en_b && !mem_we_b) rd_b0 <= mem_b[mem_addr_b];
        rd_b1 <= rd_b0;
    end
    assign mem_rdata_b = rd_b1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h2008_0005;
        return (i * 32'h9E37_79B1) + 32'h1;
    endfunction

    // ---- checking ----
    int n_tests = 0;
    int n_fail  = 0;
    int n_drv   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    typedef struct {
        logic        own;   // 1 = data port
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'h0;
        return ref_mem[a[AW+1:2]];
    endfunction

    // Scoreboard consumer for DUT A.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset && (if_rvalid || d_rvalid)) begin
                check_eq("rvalid_onehot", {31'b0, if_rvalid & d_rvalid}, 32'h0);
                check_eq("sb_nonempty", {31'b0, sb.size() != 0}, 32'h1);
                if (d_rvalid) n_drv++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("rsp_port", {31'b0, d_rvalid}, {31'b0, e.own});
                    check_eq("rsp_data", d_rvalid ? d_rdata : if_rdata, e.data);
                end
            end
        end
    end

    // ---- reference arbitration state ----
    logic        exp_lw = 1'b0;  // 0 = IF won last conflict
    logic [15:0] exp_cc = 16'h0;

    // Drive one cycle on DUT A, check combinational outputs, push expectations.
    task automatic step(input bit ireq, input logic [31:0] ia,
                        input bit dreq, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input bit chk);
        bit dwin, iwin, conf, mis;
        logic [31:0] a;
        rsp_t e;
        if_req = ireq; if_addr = ia;
        d_req = dreq; d_we = dwe; d_addr = da; d_wdata = dwd;
        #2;
        conf = ireq && dreq;
        dwin = dreq && (!ireq || exp_lw == 1'b0);
        iwin = ireq && !dwin;
        a    = dwin ? da : ia;
        mis  = (dwin || iwin) && (a[1:0] != 2'b00);
        if (chk) begin
            check_eq("if_gnt", {31'b0, if_gnt}, {31'b0, iwin});
            check_eq("d_gnt", {31'b0, d_gnt}, {31'b0, dwin});
            check_eq("stall", {31'b0, stall}, {31'b0, (ireq && !iwin) || (dreq && !dwin)});
            check_eq("mem_en", {31'b0, mem_en}, {31'b0, (dwin || iwin) && !mis});
            check_eq("mem_we", {31'b0, mem_we}, {31'b0, dwin && dwe && !mis});
            check_eq("err_misalign", {31'b0, err_misalign}, {31'b0, mis});
            if ((dwin || iwin) && !mis)
                check_eq("mem_addr", {20'b0, mem_addr}, {20'b0, a[AW+1:2]});
            if (dwin && dwe && !mis)
                check_eq("mem_wdata", mem_wdata, dwd);
        end
        if (iwin || (dwin && !dwe)) begin
            e.own = dwin; e.data = exp_rd(a);
            sb.push_back(e);
        end
        if (dwin && dwe && !mis) ref_mem[a[AW+1:2]] = dwd;
        if (conf) begin
            exp_lw = dwin;
            if (exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    endtask

    initial begin
        int drv0;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = init_word(i); mem_b[i] = init_word(i); ref_mem[i] = init_word(i);
        end
        reset = 1'b0; reset_b = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req_b = 0; if_addr_b = 0;

        // Reset state with a request pending.
        repeat (3) @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0;
        #2;
        check_eq("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
        check_eq("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check_eq("rst_err", {31'b0, err_misalign}, 32'h0);
        check_eq("rst_cnt", {16'b0, conflict_cnt}, 32'h0);
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
        @(posedge clk); #1;

        // Release with request already present: granted before the first edge.
        reset = 1'b1;
        step(1, 32'h0, 0, 0, 32'h0, 32'h0, 1);          // fetch word 0
        idle(2);
        check_eq("if_rdata_hold", if_rdata, 32'h2008_0005);

        // Four conflict cycles: D, IF, D, IF.
        for (int k = 0; k < 4; k++) begin
            step(1, 32'h4, 1, 0, 32'h8, 32'h0, 1);
            check_eq("rr_winner", {31'b0, exp_lw}, {31'b0, (k % 2) == 0});
        end
        idle(1);
        check_eq("conflict_cnt4", {16'b0, conflict_cnt}, 32'd4);

        // Write then read back word 2048.
        drv0 = n_drv;
        step(0, 32'h0, 1, 1, 32'h2000, 32'h30, 1);
        step(0, 32'h0, 1, 0, 32'h2000, 32'h0, 1);
        idle(2);
        check_eq("mem2048", mem_a[2048], 32'h30);
        check_eq("d_rvalid_once", n_drv - drv0, 32'd1);
        check_eq("d_rdata_hold30", d_rdata, 32'h30);

        // Misaligned data read.
        step(0, 32'h0, 1, 0, 32'h2002, 32'h0, 1);
        idle(2);
        check_eq("d_rdata_mis", d_rdata, 32'h0);

        // Address wrap: byte 0x4008 maps to word 2.
        step(1, 32'h4008, 0, 0, 32'h0, 32'h0, 1);
        // Data-only read, then misaligned write (no memory write, no response).
        step(0, 32'h0, 1, 0, 32'h0000_000C, 32'h0, 1);
        step(0, 32'h0, 1, 1, 32'h0000_0011, 32'hDEAD, 1);
        idle(2);

        // Saturation of conflict_cnt.
        for (int i = 0; i < 65540; i++) step(1, 32'h10, 1, 0, 32'h14, 32'h0, 0);
        idle(1);
        check_eq("cnt_sat", {16'b0, conflict_cnt}, {16'b0, exp_cc});
        check_eq("cnt_sat_ffff", {16'b0, conflict_cnt}, 32'h0000_FFFF);
        step(1, 32'h10, 1, 0, 32'h14, 32'h0, 1);
        idle(2);
        check_eq("cnt_sat_hold", {16'b0, conflict_cnt}, 32'h0000_FFFF);
        check_eq("sb_drained", sb.size(), 32'h0);

        // ---- DUT B: MEM_LAT = 2 latency ----
        @(posedge clk); #1;
        reset_b = 1'b1; if_req_b = 1'b1; if_addr_b = 32'hC;
        #2; check_eq("b_gnt", {31'b0, if_gnt_b}, 32'h1);
        @(posedge clk); #1; if_req_b = 1'b0;
        #2; check_eq("b_rvalid_early", {31'b0, if_rvalid_b}, 32'h0);
        @(posedge clk); #3;
        check_eq("b_rvalid", {31'b0, if_rvalid_b}, 32'h1);
        check_eq("b_rdata", if_rdata_b, init_word(3));

        // Read grant, then reset one cycle later.
        @(posedge clk); #1; if_req_b = 1'b1; if_addr_b = 32'h10;
        #2; check_eq("b_gnt2", {31'b0, if_gnt_b}, 32'h1);
        @(posedge clk); #1; if_req_b = 1'b0; reset_b = 1'b0;
        #2;
        check_eq("b_rst_rvalid", {30'b0, if_rvalid_b, d_rvalid_b}, 32'h0);
        check_eq("b_rst_gnt", {30'b0, if_gnt_b, d_gnt_b}, 32'h0);
        check_eq("b_rst_mem", {30'b0, mem_en_b, mem_we_b}, 32'h0);
        check_eq("b_rst_if_rdata", if_rdata_b, 32'h0);
        check_eq("b_rst_d_rdata", d_rdata_b, 32'h0);
        check_eq("b_rst_err", {31'b0, err_misalign_b}, 32'h0);
        check_eq("b_rst_cnt", {16'b0, conflict_cnt_b}, 32'h0);
        repeat (2) @(posedge clk); #1;
        reset_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2; check_eq("b_no_rvalid", {30'b0, if_rvalid_b, d_rvalid_b}, 32'h0);
            @(posedge clk); #1;
        end
        check_eq("b_if_rdata_post", if_rdata_b, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Parameters
REQ-001 SHALL have parameter AW, default 12, meaning the memory word-address width (4096 words; .data at word 2048).
REQ-002 SHALL have parameter DW, default 32, meaning the data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, range 1..4, meaning the cycles from mem_en to mem_rdata valid.

Interface
REQ-004 SHALL have clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have if_req / if_addr  in  1 / 32  instruction-fetch request and byte address.
REQ-007 SHALL have if_gnt / if_rvalid / if_rdata  out  1 / 1 / DW  fetch grant, read-valid pulse and read data.
REQ-008 SHALL have d_req / d_we / d_addr / d_wdata  in  1 / 1 / 32 / DW  data-port request, write enable, byte address and write data.
REQ-009 SHALL have d_gnt / d_rvalid / d_rdata  out  1 / 1 / DW  data-port grant, read-valid pulse and read data.
REQ-010 SHALL have mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  single-port memory command.
REQ-011 SHALL have mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read command.
REQ-012 SHALL have stall  out  1  high when any request is present but not granted this cycle.
REQ-013 SHALL have err_misalign  out  1  one-cycle pulse per granted request with addr[1:0] != 0.
REQ-014 SHALL have conflict_cnt  out  16  saturating count of cycles in which both ports requested.

Function
REQ-015 SHALL issue at most one memory command per cycle; grants are combinational in the cycle the request is accepted.
REQ-016 SHALL assert x_gnt only while x_req is high; requesters hold req, addr, we and wdata stable until gnt; dropping req before gnt aborts with no side effects.
REQ-017 SHALL grant the sole requester when only one port requests.
REQ-018 SHALL arbitrate round-robin on conflict: a last_winner flag (reset value = IF) selects the port that did not win the previous conflict; the first conflict after reset goes to the data port.
REQ-019 SHALL update last_winner only in conflict cycles.
REQ-020 SHALL drive mem_addr = addr[AW+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2^AW bytes.
REQ-021 SHALL drive mem_we = d_we when the data port is granted, and 0 for fetches.
REQ-022 SHALL track each granted read in a MEM_LAT-deep owner/valid shift register and pulse the owner's rvalid exactly MEM_LAT cycles after the grant, with rdata = mem_rdata.
REQ-023 SHALL accept a new grant every cycle (fully pipelined); read responses return in grant order.
REQ-024 SHALL complete a granted write with no rvalid pulse.
REQ-025 SHALL, for a misaligned grant, keep mem_en low, pulse err_misalign, and for reads still pulse rvalid after MEM_LAT cycles with rdata = 0.
REQ-026 SHALL hold if_rdata / d_rdata at their last values when rvalid is low.
REQ-027 SHALL increment conflict_cnt each conflict cycle and saturate at 16'hFFFF.
REQ-028 SHALL compute stall = (if_req & ~if_gnt) | (d_req & ~d_gnt).

Reset
REQ-029 SHALL, while reset is low, force all grants, mem_en, mem_we, rvalids and err_misalign to 0, rdata to 0, conflict_cnt to 0 and last_winner to IF, and clear the pipeline.
REQ-030 SHALL, on reset assertion mid-operation, discard in-flight reads so that no rvalid follows reset release.
REQ-031 SHALL consider requests in the first rising edge after reset release.

Verification
REQ-032 Bench SHALL cover: fetch only, if_addr=0x0 with memory word 0 = 0x20080005 -> if_gnt in the same cycle, if_rvalid one cycle later, if_rdata = 0x20080005.
REQ-033 Bench SHALL cover: four consecutive conflict cycles, both ports reading -> grants D, IF, D, IF; conflict_cnt = 4; stall high in every cycle.
REQ-034 Bench SHALL cover: d_we=1, d_addr=0x2000, d_wdata=0x30 followed by d_addr=0x2000 read -> memory word 2048 written, d_rdata = 0x30, exactly one d_rvalid.
REQ-035 Bench SHALL cover: d_addr=0x2002 read -> mem_en low, err_misalign for 1 cycle, d_rvalid with d_rdata = 0.
REQ-036 Bench SHALL cover: reset pulled low one cycle after a read grant with MEM_LAT=2 -> no rvalid after release; all outputs 0.
REQ-037 Bench SHALL cover: 65540 conflict cycles -> conflict_cnt = 16'hFFFF and held there.
